// File: rtl/conv3x3_mac_if.sv
// Valid/ready stream bundle shared by the window input and the result output of conv3x3_mac.
// W is the payload width.
interface conv3x3_mac_if #(
  parameter int W = 16
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/conv3x3_mac.sv
// 3x3 convolution MAC with a serially loaded kernel and a valid/ready pipeline.
// Optional macro CONV3X3_RELU_EN clamps negative saturated results to zero.
module conv3x3_mac #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_start,
  input  logic              w_valid,
  input  logic [DATA_W-1:0] w_data,
  conv3x3_mac_if.slave      win,
  conv3x3_mac_if.master     res,
  output logic              w_loaded
);

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) <<< (DATA_W - 1));

  state_t                      state_reg;
  logic [3:0]                  idx_reg;
  logic                        w_loaded_reg;
  logic signed [DATA_W-1:0]    kernel_reg [9];
  logic signed [DATA_W-1:0]    pix        [9];
  logic signed [2*DATA_W-1:0]  prod_reg   [9];
  logic signed [ACC_W-1:0]     row_next   [3];
  logic signed [ACC_W-1:0]     row_reg    [3];
  logic signed [ACC_W-1:0]     sum_reg;
  logic signed [ACC_W-1:0]     shifted;
  logic signed [DATA_W-1:0]    sat_next;
  logic [DATA_W-1:0]           out_data_reg;
  logic                        p_valid_reg, r_valid_reg, s_valid_reg, out_valid_reg;
  logic                        stall, adv, take;

  // Kernel load FSM; w_start restarts the load from any state and masks w_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      idx_reg      <= 4'd0;
      w_loaded_reg <= 1'b0;
    end else if (w_start) begin
      state_reg    <= LOAD;
      idx_reg      <= 4'd0;
      w_loaded_reg <= 1'b0;
    end else if (state_reg == LOAD && w_valid) begin
      if (idx_reg == 4'd8) begin
        state_reg    <= RUN;
        idx_reg      <= 4'd0;
        w_loaded_reg <= 1'b1;
      end else begin
        idx_reg <= idx_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) kernel_reg[i] <= '0;
    end else if (!w_start && state_reg == LOAD && w_valid) begin
      for (int i = 0; i < 9; i++)
        if (idx_reg == 4'(i)) kernel_reg[i] <= w_data;
    end
  end

  assign w_loaded  = w_loaded_reg;
  assign stall     = out_valid_reg & ~res.ready;
  assign adv       = ~stall;
  assign win.ready = (state_reg == RUN) & ~stall;
  assign take      = win.valid & win.ready;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_pix
      assign pix[gi] = win.data[gi*DATA_W +: DATA_W];
    end
    for (gi = 0; gi < 3; gi++) begin : g_row
      assign row_next[gi] = ACC_W'(prod_reg[3*gi]) + ACC_W'(prod_reg[3*gi+1])
                          + ACC_W'(prod_reg[3*gi+2]);
    end
  endgenerate

  // Flush and reset both drop every in-flight result; stall freezes the whole pipe.
  always_ff @(posedge clk) begin
    if (!rst_n || w_start) begin
      p_valid_reg   <= 1'b0;
      r_valid_reg   <= 1'b0;
      s_valid_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (adv) begin
      p_valid_reg   <= take;
      r_valid_reg   <= p_valid_reg;
      s_valid_reg   <= r_valid_reg;
      out_valid_reg <= s_valid_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) prod_reg[i] <= '0;
      for (int i = 0; i < 3; i++) row_reg[i] <= '0;
      sum_reg      <= '0;
      out_data_reg <= '0;
    end else if (adv) begin
      for (int i = 0; i < 9; i++) prod_reg[i] <= pix[i] * kernel_reg[i];
      for (int i = 0; i < 3; i++) row_reg[i] <= row_next[i];
      sum_reg <= row_reg[0] + row_reg[1] + row_reg[2];
      if (s_valid_reg) out_data_reg <= sat_next;
    end
  end

  assign shifted = sum_reg >>> FRAC_BITS;

  always_comb begin
    sat_next = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX)
      sat_next = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < SAT_MIN)
      sat_next = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef CONV3X3_RELU_EN
    if (sat_next[DATA_W-1]) sat_next = '0;
`else
`endif
  end

  assign res.valid = out_valid_reg;
  assign res.data  = out_data_reg;

endmodule

// File: tb/tb_conv3x3_mac.sv
// Directed bench for conv3x3_mac: reset, kernel load, latency, saturation, backpressure,
// flush and mid-stream reset.
module tb_conv3x3_mac;

  logic        clk;
  logic        rst_n;
  logic        w_start;
  logic        w_valid;
  logic [15:0] w_data;
  logic        w_loaded;

  conv3x3_mac_if #(.W(144)) win_if ();
  conv3x3_mac_if #(.W(16))  res_if ();

  conv3x3_mac #(.DATA_W(16), .FRAC_BITS(8), .ACC_W(36)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_start  (w_start),
    .w_valid  (w_valid),
    .w_data   (w_data),
    .win      (win_if),
    .res      (res_if),
    .w_loaded (w_loaded)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          hs_count = 0;
  logic [15:0] kern [9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (res_if.valid && res_if.ready) hs_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  function automatic logic [143:0] fill(input logic [15:0] v);
    logic [143:0] w;
    for (int j = 0; j < 9; j++) w[j*16 +: 16] = v;
    return w;
  endfunction

  function automatic logic [143:0] mkwin(input int i);
    logic [143:0] w;
    for (int j = 0; j < 9; j++) w[j*16 +: 16] = 16'(i * 55 + j * 257 - 1000);
    return w;
  endfunction

  function automatic logic [15:0] ref_conv(input logic [143:0] w);
    longint acc;
    logic [15:0] r;
    acc = 0;
    for (int j = 0; j < 9; j++)
      acc += longint'($signed(w[j*16 +: 16])) * longint'($signed(kern[j]));
    acc = acc >>> 8;
    if (acc > 32767) r = 16'h7FFF;
    else if (acc < -32768) r = 16'h8000;
    else r = acc[15:0];
`ifdef CONV3X3_RELU_EN
    if (r[15]) r = 16'h0000;
`endif
    return r;
  endfunction

  task automatic load_words();
    for (int j = 0; j < 9; j++) begin
      w_valid = 1'b1;
      w_data  = kern[j];
      @(negedge clk);
    end
    w_valid = 1'b0;
    #1;
    check_vec("w_loaded", w_loaded, 1'b1);
  endtask

  task automatic load_kernel();
    @(negedge clk);
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    load_words();
  endtask

  task automatic run_one(input string tag, input logic [143:0] w, input logic [15:0] exp);
    int n;
    int lat;
    @(negedge clk);
    win_if.valid = 1'b1;
    win_if.data  = w;
    res_if.ready = 1'b1;
    #1;
    n = 0;
    while (!win_if.ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_vec({tag, "_accept"}, win_if.ready, 1'b1);
    @(posedge clk);
    #1;
    win_if.valid = 1'b0;
    lat = 0;
    while (!res_if.valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_vec({tag, "_latency"}, 64'(lat), 64'd3);
    check_vec({tag, "_data"}, res_if.data, exp);
    @(posedge clk);
    #1;
    check_vec({tag, "_valid_drop"}, res_if.valid, 1'b0);
    check_vec({tag, "_hold"}, res_if.data, exp);
  endtask

  initial begin
    int sent, recv, cyc, hs0;
    logic [15:0] exp_q[$];
    logic [143:0] w;

    rst_n = 1'b0; w_start = 1'b0; w_valid = 1'b0; w_data = '0;
    win_if.valid = 1'b0; win_if.data = '0; res_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_vec("rst_win_ready", win_if.ready, 1'b0);
    check_vec("rst_out_valid", res_if.valid, 1'b0);
    check_vec("rst_w_loaded", w_loaded, 1'b0);
    check_vec("rst_out_data", res_if.data, 16'h0000);
    rst_n = 1'b1;

    // Windows offered with no kernel loaded must be refused.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      win_if.valid = 1'b1;
      win_if.data  = mkwin(c);
      #1;
      check_vec("noload_win_ready", win_if.ready, 1'b0);
      check_vec("noload_out_valid", res_if.valid, 1'b0);
    end
    win_if.valid = 1'b0;

    for (int j = 0; j < 9; j++) kern[j] = 16'h0000;
    kern[4] = 16'h0100;
    load_kernel();
    for (int j = 0; j < 9; j++) w[j*16 +: 16] = 16'(j * 256);
    run_one("identity", w, 16'h0400);

    // Half weight on the centre tap times -1/256 rounds toward -inf to -1/256.
    kern[4] = 16'h0080;
    load_kernel();
    w = fill(16'h0000);
    w[4*16 +: 16] = 16'hFFFF;
`ifdef CONV3X3_RELU_EN
    run_one("floor_neg", w, 16'h0000);
`else
    run_one("floor_neg", w, 16'hFFFF);
`endif

    for (int j = 0; j < 9; j++) kern[j] = 16'h0100;
    load_kernel();
    run_one("sat_pos", fill(16'h7000), 16'h7FFF);
`ifdef CONV3X3_RELU_EN
    run_one("sat_neg", fill(16'h9000), 16'h0000);
`else
    run_one("sat_neg", fill(16'h9000), 16'h8000);
`endif

    kern[0] = 16'h0100; kern[1] = 16'hFF80; kern[2] = 16'h0040;
    kern[3] = 16'h0000; kern[4] = 16'h0200; kern[5] = 16'hFFC0;
    kern[6] = 16'h0010; kern[7] = 16'h0100; kern[8] = 16'hFF00;
    load_kernel();
    sent = 0; recv = 0; cyc = 0;
    while (recv < 16 && cyc < 200) begin
      @(negedge clk);
      res_if.ready = (cyc % 2 == 0);
      win_if.valid = (sent < 16);
      win_if.data  = mkwin(sent);
      #1;
      check_vec("stream_win_ready", win_if.ready, !(res_if.valid && !res_if.ready));
      if (win_if.valid && win_if.ready) begin
        exp_q.push_back(ref_conv(win_if.data));
        sent++;
      end
      if (res_if.valid && res_if.ready) begin
        if (exp_q.size() == 0) check_vec("stream_unexpected", 1'b1, 1'b0);
        else check_vec("stream_data", res_if.data, exp_q.pop_front());
        recv++;
      end
      cyc++;
    end
    win_if.valid = 1'b0;
    res_if.ready = 1'b1;
    check_vec("stream_sent", 64'(sent), 64'd16);
    check_vec("stream_recv", 64'(recv), 64'd16);

    // Two windows in flight, then a reload: neither may surface.
    @(negedge clk);
    win_if.valid = 1'b1;
    win_if.data  = fill(16'h0100);
    #1;
    check_vec("flush_acc_a", win_if.ready, 1'b1);
    @(negedge clk);
    win_if.data = fill(16'h0300);
    #1;
    check_vec("flush_acc_b", win_if.ready, 1'b1);
    hs0 = hs_count;
    @(negedge clk);
    win_if.valid = 1'b0;
    w_start = 1'b1;
    for (int j = 0; j < 9; j++) kern[j] = 16'h0080;
    @(negedge clk);
    w_start = 1'b0;
    load_words();
    repeat (3) @(negedge clk);
    check_vec("flush_no_result", 64'(hs_count), 64'(hs0));
    run_one("reload", fill(16'h0200), 16'h0900);
    check_vec("reload_single", 64'(hs_count), 64'(hs0 + 1));

    // Reset pulse in the middle of a stream.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      win_if.valid = 1'b1;
      win_if.data  = fill(16'h0200);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_vec("midrst_out_valid", res_if.valid, 1'b0);
    check_vec("midrst_w_loaded", w_loaded, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check_vec("midrst_refuse", win_if.ready, 1'b0);
    end
    win_if.valid = 1'b0;
    load_kernel();
    run_one("after_rst", fill(16'h0200), 16'h0900);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
